// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and constants for the posted-write store buffer
package store_buffer_pkg;
    localparam int SB_AW = 32;
    typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} s_funct3_e;
    typedef struct packed {
        logic [SB_AW-1:2] addr;
        logic [31:0]      wdata;
        logic [3:0]       we;
    } sb_entry_t;
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store-request and memory-drain channels of the store buffer
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int AW = SB_AW
);
    logic          st_valid;
    logic          st_ready;
    logic [2:0]    st_funct3;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_fault;
    logic [1:0]    fault_code;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_we;
    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_ready,
        output st_ready, st_fault, fault_code, mem_valid, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_ready,
        input  st_ready, st_fault, fault_code, mem_valid, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/store_buffer_align.sv
// store_align: byte-lane enables, lane replication and legality check for one store
module store_align
    import store_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic        legal,
    output logic [1:0]  code
);
    logic is_sh, is_sw, known, misalign;
    always_comb begin
        is_sh    = funct3 == SH;
        is_sw    = funct3 == SW;
        known    = funct3 == SB || is_sh || is_sw;
        misalign = (is_sh && off[0]) || (is_sw && off != 2'b00);
        we       = is_sw ? 4'b1111 : is_sh ? 4'b0011 << off : 4'b0001 << off;
        wdata    = is_sw ? data : is_sh ? {2{data[15:0]}} : {4{data[7:0]}};
        code     = !known ? FAULT_ILLEGAL : misalign ? FAULT_MISALIGN : FAULT_NONE;
        legal    = code == FAULT_NONE;
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between S-type decode and data memory
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    sb_entry_t       ring [DEPTH];
    sb_entry_t       head;
    logic [PW-1:0]   wp, rp;
    logic [PW:0]     count;
    logic [3:0]      a_we;
    logic [31:0]     a_wdata;
    logic            a_legal;
    logic [1:0]      a_code;
    logic            take, push, pop;
    logic            unused_ld;
    store_align u_align (
        .funct3 (bus.st_funct3),
        .off    (bus.st_addr[1:0]),
        .data   (bus.st_data),
        .we     (a_we),
        .wdata  (a_wdata),
        .legal  (a_legal),
        .code   (a_code)
    );
    assign full          = count == (PW+1)'(DEPTH);
    assign empty         = count == '0;
    assign bus.st_ready  = !full;
    assign take          = bus.st_valid && bus.st_ready;
    assign push          = take && a_legal;
    assign head          = ring[rp];
    assign bus.mem_valid = !empty;
    assign pop           = bus.mem_valid && bus.mem_ready;
    assign bus.mem_addr  = {head.addr, 2'b00};
    assign bus.mem_wdata = head.wdata;
    assign bus.mem_we    = bus.mem_valid ? head.we : 4'b0000;
    assign unused_ld     = ^ld_addr[1:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            bus.st_fault   <= 1'b0;
            bus.fault_code <= FAULT_NONE;
        end else begin
            wp             <= push ? wp + 1'b1 : wp;
            rp             <= pop ? rp + 1'b1 : rp;
            count          <= count + (PW+1)'(push) - (PW+1)'(pop);
            bus.st_fault   <= take && !a_legal;
            bus.fault_code <= (take && !a_legal) ? a_code : FAULT_NONE;
        end
    end
    // Payload storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            ring[wp] <= '{addr: bus.st_addr[AW-1:2], wdata: a_wdata, we: a_we};
    end
    // An entry is occupied when its distance from the head is below count.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ld_hit = ld_hit || (({1'b0, PW'(i) - rp} < count) && ring[i].addr == ld_addr[AW-1:2]);
    end
endmodule
